// File: rtl/tmds_pkg.sv
// Shared constants for the multi-channel TMDS encoder: period modes, control,
// guard-band and TERC4 symbol tables. TERC4 table exists only with TMDS_TERC4_EN.
package tmds_pkg;

  localparam logic [1:0] MODE_CTRL  = 2'd0;
  localparam logic [1:0] MODE_VIDEO = 2'd1;
  localparam logic [1:0] MODE_VGB   = 2'd2;
  localparam logic [1:0] MODE_DATA  = 2'd3;

  localparam logic [9:0] RST_CODE = 10'b1101010100;

  // Indexed by cd; highest index listed first.
  localparam logic [3:0][9:0] CTRL_CODE = {
    10'b1010101011, 10'b0101010100, 10'b0010101011, 10'b1101010100
  };

  // Indexed by channel index mod 3.
  localparam logic [2:0][9:0] GB_CODE = {
    10'b1011001100, 10'b0100110011, 10'b1011001100
  };

`ifdef TMDS_TERC4_EN
  localparam logic [15:0][9:0] TERC4_CODE = {
    10'b1011000011, 10'b0101100011, 10'b1001110001, 10'b1010001110,
    10'b1011000110, 10'b0110011100, 10'b0100111001, 10'b1011001100,
    10'b0100111100, 10'b0110001110, 10'b0100011110, 10'b0101110001,
    10'b1011100010, 10'b1011100100, 10'b1001100011, 10'b1010011100
  };
`endif

  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/tmds_channel_enc.sv
// One TMDS channel: stage 1 builds q_m and the non-video code, stage 2 picks
// the output symbol and tracks the signed running disparity.
module tmds_channel_enc
  import tmds_pkg::*;
#(
  parameter int CNT_W  = 5,
  parameter int CH_IDX = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode,
  input  logic [7:0] vd,
  input  logic [1:0] cd,
  input  logic [3:0] td,
  output logic [9:0] tmds
);

  localparam logic [9:0] GB = GB_CODE[CH_IDX % 3];

  logic [3:0] n1_in;
  logic       use_xnor;
  logic [8:0] qm;
  logic [9:0] code_in;

  logic [1:0] s1_mode;
  logic [8:0] s1_qm;
  logic [3:0] s1_n1;
  logic [9:0] s1_code;

  logic signed [CNT_W-1:0] cnt, nxt_cnt, diff, two_q8, two_nq8;
  logic [9:0] vid_out;
  logic       q8, cnt_pos, cnt_neg, d_pos, d_neg;

  always_comb begin
    n1_in    = ones8(vd);
    use_xnor = (n1_in > 4'd4) || (n1_in == 4'd4 && !vd[0]);
    qm       = '0;
    qm[0]    = vd[0];
    for (int i = 1; i < 8; i++)
      qm[i] = use_xnor ? ~(qm[i-1] ^ vd[i]) : (qm[i-1] ^ vd[i]);
    qm[8] = ~use_xnor;
  end

  always_comb begin
    code_in = CTRL_CODE[cd];
    case (mode)
      MODE_VGB:  code_in = GB;
`ifdef TMDS_TERC4_EN
      MODE_DATA: code_in = TERC4_CODE[td];
`endif
      default:   code_in = CTRL_CODE[cd];
    endcase
  end

`ifndef TMDS_TERC4_EN
  logic unused_td;
  assign unused_td = ^td;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_mode <= MODE_CTRL;
      s1_qm   <= '0;
      s1_n1   <= '0;
      s1_code <= RST_CODE;
    end else begin
      s1_mode <= mode;
      s1_qm   <= qm;
      s1_n1   <= ones8(qm[7:0]);
      s1_code <= code_in;
    end
  end

  // diff = N1 - N0 of q_m[7:0] = 2*N1 - 8, kept in counter width
  always_comb begin
    q8      = s1_qm[8];
    diff    = CNT_W'({s1_n1, 1'b0}) - CNT_W'(4'd8);
    two_q8  = q8 ? CNT_W'(2) : '0;
    two_nq8 = q8 ? '0 : CNT_W'(2);
    cnt_neg = cnt[CNT_W-1];
    cnt_pos = !cnt[CNT_W-1] && (cnt != '0);
    d_neg   = diff[CNT_W-1];
    d_pos   = !diff[CNT_W-1] && (diff != '0);
    if (cnt == '0 || diff == '0) begin
      vid_out = {~q8, q8, q8 ? s1_qm[7:0] : ~s1_qm[7:0]};
      nxt_cnt = q8 ? (cnt + diff) : (cnt - diff);
    end else if ((cnt_pos && d_pos) || (cnt_neg && d_neg)) begin
      vid_out = {1'b1, q8, ~s1_qm[7:0]};
      nxt_cnt = cnt + two_q8 - diff;
    end else begin
      vid_out = {1'b0, q8, s1_qm[7:0]};
      nxt_cnt = cnt - two_nq8 + diff;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmds <= RST_CODE;
      cnt  <= '0;
    end else if (s1_mode == MODE_VIDEO) begin
      tmds <= vid_out;
      cnt  <= nxt_cnt;
    end else begin
      tmds <= s1_code;
      cnt  <= '0;
    end
  end

endmodule

// File: rtl/tmds_encoder_mc.sv
// Multi-channel TMDS encoder, fixed 2-cycle latency. Define TMDS_TERC4_EN to
// enable TERC4 coding in DATA mode; otherwise DATA encodes like CTRL.
module tmds_encoder_mc
  import tmds_pkg::*;
#(
  parameter int CHANNELS = 3,
  parameter int CNT_W    = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            mode,
  input  logic [CHANNELS*8-1:0] vd,
  input  logic [CHANNELS*2-1:0] cd,
  input  logic [CHANNELS*4-1:0] td,
  output logic [CHANNELS*10-1:0] tmds,
  output logic                  tmds_valid
);

  localparam int STAGES = 2;

  logic [STAGES-1:0] vld_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe <= '0;
    else        vld_pipe <= {vld_pipe[STAGES-2:0], 1'b1};
  end

  assign tmds_valid = vld_pipe[STAGES-1];

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    tmds_channel_enc #(
      .CNT_W  (CNT_W),
      .CH_IDX (i)
    ) u_enc (
      .clk   (clk),
      .rst_n (rst_n),
      .mode  (mode),
      .vd    (vd[8*i +: 8]),
      .cd    (cd[2*i +: 2]),
      .td    (td[4*i +: 4]),
      .tmds  (tmds[10*i +: 10])
    );
  end

endmodule

// File: tb/tb_tmds_encoder_mc.sv
// Directed vector table plus hand-written sequences and a reference-model
// stream for the 3-channel TMDS encoder.
module tb_tmds_encoder_mc;

  localparam logic [9:0] C00 = 10'b1101010100;
  localparam logic [9:0] C01 = 10'b0010101011;
  localparam logic [9:0] C10 = 10'b0101010100;
  localparam logic [9:0] C11 = 10'b1010101011;
  localparam logic [9:0] GB0 = 10'b1011001100;
  localparam logic [9:0] GB1 = 10'b0100110011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [23:0] vd = '0;
  logic [5:0]  cd = '0;
  logic [11:0] td = '0;
  logic [29:0] tmds;
  logic        tmds_valid;

  int checks = 0;
  int errors = 0;

  tmds_encoder_mc #(.CHANNELS(3), .CNT_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .vd         (vd),
    .cd         (cd),
    .td         (td),
    .tmds       (tmds),
    .tmds_valid (tmds_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  mode;
    logic [23:0] vd;
    logic [5:0]  cd;
    logic [11:0] td;
    logic [29:0] exp;
  } vec_t;

  vec_t vecs[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [29:0] act, input logic [29:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] m, input logic [23:0] v,
                       input logic [5:0] c, input logic [11:0] t);
    mode = m; vd = v; cd = c; td = t;
  endtask

  function automatic logic [9:0] ctrl_ref(input logic [1:0] c);
    case (c)
      2'b00:   return C00;
      2'b01:   return C01;
      2'b10:   return C10;
      default: return C11;
    endcase
  endfunction

  // DVI 1.0 reference encoder in plain integer arithmetic
  function automatic logic [9:0] ref_enc(input logic [7:0] d, input int cin, output int cout);
    int n1, n1q;
    logic x;
    logic [8:0] q;
    logic [9:0] r;
    n1 = $countones(d);
    x = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    q = '0;
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = x ? (q[i-1] ~^ d[i]) : (q[i-1] ^ d[i]);
    q[8] = !x;
    n1q = $countones(q[7:0]);
    if (cin == 0 || n1q == 4) begin
      r = q[8] ? {2'b01, q[7:0]} : {2'b10, ~q[7:0]};
      cout = cin + (q[8] ? (2*n1q - 8) : (8 - 2*n1q));
    end else if ((cin > 0 && n1q > 4) || (cin < 0 && n1q < 4)) begin
      r = {1'b1, q[8], ~q[7:0]};
      cout = cin + 2*int'(q[8]) + (8 - 2*n1q);
    end else begin
      r = {1'b0, q[8], q[7:0]};
      cout = cin - (q[8] ? 0 : 2) + (2*n1q - 8);
    end
    return r;
  endfunction

  initial begin
    logic [29:0] expq[$];
    logic [29:0] e;
    int mcnt[3];
    int nc;
    int r;

    vecs[0] = '{"ctrl_a", 2'd0, 24'h0, 6'b11_10_01, 12'h0, {C11, C10, C01}};
    vecs[1] = '{"ctrl_b", 2'd0, 24'h0, 6'b00_01_10, 12'h0, {C00, C01, C10}};
    vecs[2] = '{"vgb",    2'd2, 24'h0, 6'b00_00_00, 12'h0, {GB0, GB1, GB0}};
    vecs[3] = '{"vid_a",  2'd1, 24'h01_FF_00, 6'b0, 12'h0, {10'h1FF, 10'h200, 10'h100}};
    vecs[4] = '{"vid_b",  2'd1, 24'h10_AA_55, 6'b0, 12'h0, {10'h1F0, 10'h233, 10'h133}};
`ifdef TMDS_TERC4_EN
    vecs[5] = '{"data_a", 2'd3, 24'h0, 6'b11_11_11, 12'hFA0,
                {10'b1011000011, 10'b0110011100, 10'b1010011100}};
    vecs[6] = '{"data_b", 2'd3, 24'h0, 6'b00_01_10, 12'h583,
                {10'b0100011110, 10'b1011001100, 10'b1011100010}};
`else
    vecs[5] = '{"data_a", 2'd3, 24'h0, 6'b11_11_11, 12'hFA0, {C11, C11, C11}};
    vecs[6] = '{"data_b", 2'd3, 24'h0, 6'b00_01_10, 12'h583, {C00, C01, C10}};
`endif

    // Reset state, then release with ch0 cd=01
    drive(2'd0, 24'h0, 6'b00_00_01, 12'h0);
    #12;
    chk("reset_tmds", tmds, {C00, C00, C00});
    chk("reset_valid", {29'd0, tmds_valid}, 30'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();
    chk("valid_after_1", {29'd0, tmds_valid}, 30'd0);
    step();
    chk("valid_after_2", {29'd0, tmds_valid}, 30'd1);
    chk("first_ctrl", tmds, {C00, C00, C01});

    // Vector table, each preceded by a CTRL flush so cnt starts at 0
    foreach (vecs[k]) begin
      drive(2'd0, 24'h0, 6'b0, 12'h0);
      step(); step();
      drive(vecs[k].mode, vecs[k].vd, vecs[k].cd, vecs[k].td);
      step(); step();
      chk(vecs[k].name, tmds, vecs[k].exp);
    end

    // Two VIDEO 0x00 in a row: disparity carries -8 into the second
    drive(2'd0, 24'h0, 6'b0, 12'h0);
    step(); step();
    drive(2'd1, 24'h0, 6'b0, 12'h0);
    step(); step();
    chk("vid00_first", tmds, {3{10'h100}});
    step();
    chk("vid00_second", tmds, {3{10'h3FF}});

    // VIDEO, CTRL, VIDEO: counter cleared by the control symbol
    drive(2'd0, 24'h0, 6'b0, 12'h0);
    step(); step();
    drive(2'd1, 24'h0, 6'b0, 12'h0);
    step();
    drive(2'd0, 24'h0, 6'b0, 12'h0);
    step();
    chk("vcv_video1", tmds, {3{10'h100}});
    drive(2'd1, 24'h0, 6'b0, 12'h0);
    step();
    chk("vcv_ctrl", tmds, {3{C00}});
    step();
    chk("vcv_video2", tmds, {3{10'h100}});

    // Mixed-mode random stream against the reference model
    drive(2'd0, 24'h0, 6'b0, 12'h0);
    step(); step();
    mcnt = '{0, 0, 0};
    nc = 0;
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 9);
      drive(r < 7 ? 2'd1 : (r < 9 ? 2'd0 : 2'd2), 24'($urandom), 6'($urandom), 12'($urandom));
      for (int c = 0; c < 3; c++) begin
        int nxt;
        if (mode == 2'd1) begin
          e[10*c +: 10] = ref_enc(vd[8*c +: 8], mcnt[c], nxt);
          mcnt[c] = nxt;
        end else begin
          e[10*c +: 10] = (mode == 2'd2) ? ((c == 1) ? GB1 : GB0) : ctrl_ref(cd[2*c +: 2]);
          mcnt[c] = 0;
        end
      end
      expq.push_back(e);
      step();
      if (n >= 1) begin
        e = expq.pop_front();
        if (tmds !== e) $display("FAIL stream[%0d]: got %h expected %h", n - 1, tmds, e);
        checks++;
        if (tmds !== e) errors++;
        nc++;
      end
    end

    // Asynchronous reset mid-stream
    drive(2'd1, 24'h123456, 6'b0, 12'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_tmds", tmds, {3{C00}});
    chk("midrst_valid", {29'd0, tmds_valid}, 30'd0);
    step();
    rst_n = 1'b1;
    drive(2'd1, 24'h0, 6'b0, 12'h0);
    step();
    chk("postrst_valid1", {29'd0, tmds_valid}, 30'd0);
    step();
    chk("postrst_valid2", {29'd0, tmds_valid}, 30'd1);
    chk("postrst_video", tmds, {3{10'h100}});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
